// File: rtl/shift_add_mul_pkg.sv
// Shared constants and state encoding for the iterative shift-and-add multiplier.
package shift_add_mul_pkg;
   localparam int WIDTH = 32;
   localparam int CNT_W = 6;

   // NEG is kept in both builds so the encoding never changes between configurations.
   typedef enum logic [1:0] {IDLE, CALC, NEG, DONE} state_t;
endpackage

// File: rtl/shift_add_mul_add.sv
// Add: 32-bit carry-lookahead adder (Kogge-Stone prefix carries), no carry-in or carry-out.
module Add (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum
);
   logic [31:0] g, p, gg, pp;

   always_comb begin
      g  = a & b;
      p  = a ^ b;
      gg = g;
      pp = p;
      // Five doubling stages: gg[i] ends up as the carry out of bit i.
      for (int d = 1; d < 32; d = d * 2) begin
         gg = gg | (pp & (gg << d));
         pp = pp & (pp << d);
      end
      sum = p ^ {gg[30:0], 1'b0};
   end
endmodule

// File: rtl/shift_add_mul.sv
// Iterative 32x32->64 shift-and-add multiplier, one multiplier bit per cycle through Add.
// Define SHIFT_ADD_MUL_SIGNED_EN to add op_signed and the sign-restoring NEG state.
module shift_add_mul
   import shift_add_mul_pkg::*;
#(
   parameter int WIDTH = shift_add_mul_pkg::WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
`ifdef SHIFT_ADD_MUL_SIGNED_EN
   input  logic               op_signed,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] prod
);
   localparam logic [2*WIDTH-1:0] ONE_W2 = 1;

   state_t           state;
   logic [WIDTH-1:0] mcand, acc_hi, acc_lo, add_b, sum;
   logic [CNT_W-1:0] cnt;
   logic             carry;
`ifdef SHIFT_ADD_MUL_SIGNED_EN
   logic             neg;
`endif

   assign add_b = acc_lo[0] ? mcand : '0;

   Add u_add (
      .a   (acc_hi),
      .b   (add_b),
      .sum (sum)
   );

   // Add has no carry-out, so recover it from the operand and result MSBs.
   assign carry = (acc_hi[WIDTH-1] & add_b[WIDTH-1]) |
                  ((acc_hi[WIDTH-1] ^ add_b[WIDTH-1]) & ~sum[WIDTH-1]);

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign prod      = {acc_hi, acc_lo};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         mcand  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         cnt    <= '0;
`ifdef SHIFT_ADD_MUL_SIGNED_EN
         neg    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (in_valid) begin
`ifdef SHIFT_ADD_MUL_SIGNED_EN
               mcand  <= (op_signed && op_a[WIDTH-1]) ? -op_a : op_a;
               acc_lo <= (op_signed && op_b[WIDTH-1]) ? -op_b : op_b;
               neg    <= op_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
`else
               mcand  <= op_a;
               acc_lo <= op_b;
`endif
               acc_hi <= '0;
               cnt    <= '0;
               state  <= CALC;
            end
            CALC: begin
               {acc_hi, acc_lo} <= {carry, sum, acc_lo[WIDTH-1:1]};
               cnt              <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH-1)) begin
`ifdef SHIFT_ADD_MUL_SIGNED_EN
                  state <= neg ? NEG : DONE;
`else
                  state <= DONE;
`endif
               end
            end
`ifdef SHIFT_ADD_MUL_SIGNED_EN
            NEG: begin
               {acc_hi, acc_lo} <= ~{acc_hi, acc_lo} + ONE_W2;
               state            <= DONE;
            end
`endif
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifndef SHIFT_ADD_MUL_SIGNED_EN
   logic unused_one;
   assign unused_one = ^ONE_W2;
`endif
endmodule

// File: tb/tb_shift_add_mul.sv
// Randomized bench for shift_add_mul with a cycle-level behavioural model and directed literal cases.
module tb_shift_add_mul;
   logic        clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, out_ready = 1'b1, op_signed = 1'b0;
   logic [31:0] op_a = '0, op_b = '0;
   logic        in_ready, out_valid;
   logic [63:0] prod;
   int          checks = 0, failures = 0;

   always #5 clk = ~clk;

   shift_add_mul #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
`ifdef SHIFT_ADD_MUL_SIGNED_EN
      .op_signed (op_signed),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .prod      (prod)
   );

   function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
      longint sa, sb;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   // Model: idle / busy for a fixed number of cycles / done until taken.
   logic        m_busy = 1'b0, m_done = 1'b0, m_zero = 1'b1;
   int          m_left = 0;
   logic [63:0] m_exp = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_zero <= 1'b1;
         m_left <= 0;
         m_exp  <= '0;
      end else if (m_done) begin
         if (out_ready) m_done <= 1'b0;
      end else if (m_busy) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
         end
      end else if (in_valid) begin
         m_busy <= 1'b1;
         m_zero <= 1'b0;
         m_left <= 32 + int'(op_signed & (op_a[31] ^ op_b[31]));
         m_exp  <= ref_prod(op_a, op_b, op_signed);
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("in_ready", 64'(in_ready), 64'(!m_busy && !m_done));
      chk("out_valid", 64'(out_valid), 64'(m_done));
      if (m_done)      chk("prod", prod, m_exp);
      else if (m_zero) chk("prod_zero", prod, 64'h0);
   end

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit use_lit, input logic [63:0] lit, input int exp_lat,
                         input int hold, input int pulse_at, input int reset_at, input bit noise);
      int lat, w;
      w = 0;
      while (!in_ready && w < 50) begin
         @(posedge clk); #2;
         w++;
      end
      if (!in_ready) begin
         chk("accept_wait", 64'(in_ready), 64'h1);
         return;
      end
      in_valid = 1'b1; op_a = a; op_b = b; op_signed = s;
      @(posedge clk); #2;
      in_valid = 1'b0;
      lat = 0;
      while (lat < 100) begin
         @(posedge clk); #2;
         lat++;
         if (out_valid) break;
         if (lat == reset_at) begin
            rst_n = 1'b0;
            #1;
            chk("rst_out_valid", 64'(out_valid), 64'h0);
            chk("rst_in_ready", 64'(in_ready), 64'h1);
            chk("rst_prod", prod, 64'h0);
            @(posedge clk); #2;
            rst_n = 1'b1;
            return;
         end
         if (lat == pulse_at || (noise && $urandom_range(0, 1) == 1)) begin
            in_valid = 1'b1; op_a = $urandom; op_b = $urandom;
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      if (!out_valid) begin
         chk("done_timeout", 64'(out_valid), 64'h1);
         return;
      end
      if (use_lit) begin
         chk("latency", 64'(lat), 64'(exp_lat));
         chk("lit_prod", prod, lit);
      end
      if (hold > 0) begin
         out_ready = 1'b0;
         repeat (hold) @(posedge clk);
         #2;
         if (use_lit) begin
            chk("held_prod", prod, lit);
            chk("held_in_ready", 64'(in_ready), 64'h0);
         end
         out_ready = 1'b1;
      end
      @(posedge clk); #2;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      chk("reset_prod", prod, 64'h0);
      chk("reset_in_ready", 64'(in_ready), 64'h1);

      run_op(32'd3, 32'd5, 1'b0, 1, 64'h0000_0000_0000_000F, 32, 0, -1, -1, 0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1, 64'hFFFF_FFFE_0000_0001, 32, 0, -1, -1, 0);
      run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1, 64'h0B00_EA4E_242D_2080, 32, 10, -1, -1, 0);
      run_op(32'h0001_0001, 32'h0000_FFFF, 1'b0, 1, 64'h0000_0000_FFFF_FFFF, 32, 2, 5, -1, 0);
      run_op(32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 0, 64'h0, 0, 0, -1, 17, 0);
      run_op(32'd7, 32'd6, 1'b0, 1, 64'h0000_0000_0000_002A, 32, 0, -1, -1, 0);
`ifdef SHIFT_ADD_MUL_SIGNED_EN
      run_op(32'hFFFF_FFFD, 32'd7, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FFEB, 33, 0, -1, -1, 0);
      run_op(32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 1, 64'h0000_0000_0000_0010, 32, 0, -1, -1, 0);
      run_op(32'h8000_0000, 32'd1, 1'b1, 1, 64'hFFFF_FFFF_8000_0000, 33, 0, -1, -1, 0);
`endif

      for (int i = 0; i < 40; i++) begin
         logic [31:0] ra, rb;
         logic        rs;
         ra = (i % 8 == 0) ? 32'h8000_0000 : $urandom;
         rb = (i % 8 == 3) ? 32'hFFFF_FFFF : $urandom;
`ifdef SHIFT_ADD_MUL_SIGNED_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         run_op(ra, rb, rs, 0, 64'h0, 0, $urandom_range(0, 3), -1, -1, 1);
      end

      repeat (3) @(posedge clk);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
